// File: rtl/dmem_if.sv
// Load/store request and response channels between a datapath port and data memory.
// The master modport is the requester; the slave modport is the memory responder.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: fixed-latency word load/store with byte enables.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned addresses with resp_err instead of ignoring addr[1:0].
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             we_q;
  logic [AW-1:0]    idx_q;
  logic [WIDTH-1:0] wdata_q;
  logic [3:0]       be_q;
  logic             mis_q;

  logic             accept;
  logic             mis_in;
  logic             commit;
  logic             c_we;
  logic [AW-1:0]    c_idx;
  logic [WIDTH-1:0] c_wdata;
  logic [3:0]       c_be;
  logic             c_mis;
  logic [WIDTH-1:0] rd_word;
  logic             unused_addr;

  assign accept = bus.req_valid && (state_q == IDLE);

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis_in = (bus.req_addr[1:0] != 2'b00);
`else
  assign mis_in = 1'b0;
`endif

  // Upper bits alias by truncation; byte offset only matters to the alignment check.
  assign unused_addr = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};

  // With LATENCY=1 the commit happens on the accept edge, so it uses the live request.
  always_comb begin
    c_we    = we_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    c_be    = be_q;
    c_mis   = mis_q;
    commit  = (state_q == WAIT) && (cnt_q == WAIT_LAST);
    if (LATENCY == 1) begin
      c_we    = bus.req_we;
      c_idx   = bus.req_addr[AW+1:2];
      c_wdata = bus.req_wdata;
      c_be    = bus.req_be;
      c_mis   = mis_in;
      commit  = accept;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_q [DEPTH];

      always_ff @(posedge clk) begin
        if (!reset && commit && c_we && !c_mis && c_be[gi]) begin
          mem_q[c_idx] <= c_wdata[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = mem_q[c_idx];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 1) ? RESP : WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      rdata_d = (c_we || c_mis) ? '0 : rd_word;
      err_d   = c_mis;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      idx_q   <= bus.req_addr[AW+1:2];
      wdata_q <= bus.req_wdata;
      be_q    <= bus.req_be;
      mis_q   <= mis_in;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a word-array model predicts every response.
// Tasks start and end just after a falling clock edge.
module tb_dmem_responder;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;
  localparam int AW      = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_if bus ();

  dmem_responder #(.DEPTH(DEPTH), .WIDTH(32), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          tests_run    = 0;
  int          tests_failed = 0;
  exp_t        sb_q[$];
  logic [31:0] model [DEPTH];
  int          cyc = 0;
  int          accept_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input bit push);
    exp_t          e;
    logic [AW-1:0] idx;
    logic          mis;
    idx = addr[AW+1:2];
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    tests_run++;
    if (bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL issue_ready: req_ready=%b required 1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    if (push) begin
      if (mis) begin
        e = '{rdata: 32'h0, err: 1'b1};
      end else if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
        e = '{rdata: 32'h0, err: 1'b0};
      end else begin
        e = '{rdata: model[idx], err: 1'b0};
      end
      sb_q.push_back(e);
    end
    @(posedge clk);
    accept_cyc = cyc;
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.resp_valid !== 1'b1 && lat < 40);
  endtask

  task automatic finish_resp(input string name, input logic we, input logic [31:0] addr,
                             output logic [31:0] got);
    exp_t e;
    got = bus.resp_rdata;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s_scoreboard: response with empty queue", name);
    end else begin
      e = sb_q.pop_front();
      if (bus.resp_rdata !== e.rdata || bus.resp_err !== e.err) begin
        tests_failed++;
        $display("FAIL %s_data: rdata=%h err=%b required rdata=%h err=%b",
                 name, bus.resp_rdata, bus.resp_err, e.rdata, e.err);
      end
    end
    $display("[TB] %s we=%b addr=%h rdata=%h err=%b", name, we, addr, bus.resp_rdata, bus.resp_err);
    @(negedge clk);
    tests_run++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL %s_release: resp_valid=%b req_ready=%b rdata=%h required 0 1 0",
               name, bus.resp_valid, bus.req_ready, bus.resp_rdata);
    end
  endtask

  task automatic txn(input string name, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, output logic [31:0] got);
    int lat;
    bus.resp_ready = 1'b1;
    issue(we, addr, wdata, be, 1'b1);
    wait_resp(lat);
    tests_run++;
    if (lat != LATENCY) begin
      tests_failed++;
      $display("FAIL %s_latency: %0d cycles required %0d", name, lat, LATENCY);
    end
    finish_resp(name, we, addr, got);
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_be = '0;   bus.resp_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 ||
        bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
               bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    logic [31:0] got;
    txn("store_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, got);
    txn("load_full", 1'b0, 32'h10, 32'h0, 4'h0, got);
    tests_run++;
    if (got !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL load_full_const: rdata=%h required deadbeef", got);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] got;
    txn("store_be1", 1'b1, 32'h10, 32'h000000AA, 4'b0001, got);
    txn("load_be1", 1'b0, 32'h10, 32'h0, 4'hF, got);
    tests_run++;
    if (got !== 32'hDEADBEAA) begin
      tests_failed++;
      $display("FAIL byte_enable_const: rdata=%h required deadbeaa", got);
    end
    txn("store_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, got);
    txn("load_be0", 1'b0, 32'h10, 32'h0, 4'h0, got);
    tests_run++;
    if (got !== 32'hDEADBEAA) begin
      tests_failed++;
      $display("FAIL zero_be_const: rdata=%h required deadbeaa", got);
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [31:0] held;
    logic [31:0] got;
    bus.resp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    wait_resp(lat);
    held = bus.resp_rdata;
    // A stray store during RESP must be ignored.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h10;
    bus.req_wdata = 32'h0; bus.req_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== held || bus.req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL backpressure_hold%0d: valid=%b rdata=%h ready=%b required 1 %h 0",
                 i, bus.resp_valid, bus.resp_rdata, bus.req_ready, held);
      end
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    finish_resp("bp_load", 1'b0, 32'h10, got);
    txn("bp_reload", 1'b0, 32'h10, 32'h0, 4'h0, got);
    tests_run++;
    if (got !== 32'hDEADBEAA) begin
      tests_failed++;
      $display("FAIL stray_store_ignored: rdata=%h required deadbeaa", got);
    end
  endtask

  task automatic test_reset_abort();
    int          lat;
    logic [31:0] got;
    txn("store_pre", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, got);
    bus.resp_ready = 1'b1;
    issue(1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.resp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL wait_abort_noresp%0d: resp_valid=%b required 0", i, bus.resp_valid);
      end
    end
    txn("load_after_abort", 1'b0, 32'h20, 32'h0, 4'h0, got);
    tests_run++;
    if (got !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL wait_abort_nowrite: rdata=%h required cafef00d", got);
    end
    // Reset while the store response is pending: response dropped, write kept.
    bus.resp_ready = 1'b0;
    issue(1'b1, 32'h30, 32'h55AA55AA, 4'hF, 1'b1);
    wait_resp(lat);
    void'(sb_q.pop_front());
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL resp_reset_drop: valid=%b ready=%b required 0 1", bus.resp_valid, bus.req_ready);
    end
    txn("load_after_resp_reset", 1'b0, 32'h30, 32'h0, 4'h0, got);
    tests_run++;
    if (got !== 32'h55AA55AA) begin
      tests_failed++;
      $display("FAIL resp_reset_kept: rdata=%h required 55aa55aa", got);
    end
  endtask

  task automatic test_alias();
    logic [31:0] got;
    txn("store_w0", 1'b1, 32'h0, 32'h0BADCAFE, 4'hF, got);
    txn("load_alias", 1'b0, 32'h400, 32'h0, 4'h0, got);
    tests_run++;
    if (got !== 32'h0BADCAFE) begin
      tests_failed++;
      $display("FAIL alias_0x400: rdata=%h required 0badcafe", got);
    end
    txn("store_wrap", 1'b1, 32'hFFFF_FFFC, 32'h600DF00D, 4'hF, got);
    txn("load_last", 1'b0, 32'h3FC, 32'h0, 4'h0, got);
    tests_run++;
    if (got !== 32'h600DF00D) begin
      tests_failed++;
      $display("FAIL wrap_last_word: rdata=%h required 600df00d", got);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] got;
    txn("load_0x12", 1'b0, 32'h12, 32'h0, 4'h0, got);
`ifdef DMEM_ALIGN_CHECK_EN
    tests_run++;
    if (got !== 32'h0) begin
      tests_failed++;
      $display("FAIL misalign_rdata: rdata=%h required 0", got);
    end
    txn("store_mis", 1'b1, 32'h11, 32'h0, 4'hF, got);
    txn("load_after_mis", 1'b0, 32'h10, 32'h0, 4'h0, got);
    tests_run++;
    if (got !== 32'hDEADBEAA) begin
      tests_failed++;
      $display("FAIL misalign_nowrite: rdata=%h required deadbeaa", got);
    end
`else
    tests_run++;
    if (got !== 32'hDEADBEAA) begin
      tests_failed++;
      $display("FAIL offset_ignored: rdata=%h required deadbeaa", got);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    int          prev;
    logic        we;
    logic [31:0] addr;
    for (int i = 0; i < 8; i++) begin
      txn("b2b_init", 1'b1, 32'h100 + 32'(4*i), $urandom, 4'hF, got);
    end
    prev = accept_cyc;
    for (int i = 0; i < 16; i++) begin
      we   = 1'($urandom_range(0, 1));
      addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
      txn("b2b", we, addr, $urandom, 4'($urandom_range(0, 15)), got);
      tests_run++;
      if (accept_cyc - prev != LATENCY + 1) begin
        tests_failed++;
        $display("FAIL b2b_interval: %0d cycles required %0d", accept_cyc - prev, LATENCY + 1);
      end
      prev = accept_cyc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_backpressure();
    test_reset_abort();
    test_alias();
    test_misalign();
    test_back_to_back();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
